dof_pipe_stage: RTL and testbench

Registered decode/operand-fetch stage for the pipelined datapath. Sits between instruction fetch and execute.
- Takes PC, IR, decoder control fields and register-file read data.
- Builds operand buses (constant unit, PC select, R0 rule, data forwarding from EX/WB).
- Detects load-use hazards and inserts bubbles.
- Presents everything to execute through a pipeline register with valid, stall and flush.

---
 rtl/dof_pkg.sv | 29 ++
 rtl/dof_fwd_mux.sv | 50 +++++
 rtl/dof_pipe_stage.sv | 171 +++++++++++++++++
 tb/tb_dof_pipe_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dof_pkg.sv
// Shared definitions for the decode/operand-fetch stage: control bundle layout,
// bubble constant, load encoding and parameter defaults.
package dof_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 16;
  localparam int RA_W_DEF   = 5;
  localparam int IM_W_DEF   = 15;

  localparam logic [1:0] MD_LOAD = 2'b01;

  localparam int MD_W = 2;
  localparam int BS_W = 2;
  localparam int FS_W = 5;
  localparam int SH_W = 5;

  typedef struct packed {
    logic            rw;
    logic            ps;
    logic            mw;
    logic [MD_W-1:0] md;
    logic [BS_W-1:0] bs;
    logic [FS_W-1:0] fs;
    logic [SH_W-1:0] sh;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/dof_fwd_mux.sv
// Per-operand source resolver: R0 rule, EX/WB forwarding and producer-match flags.
// Forwarding is only built when DOF_FWD_EN is defined.
module dof_fwd_mux
  import dof_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic [RA_W-1:0]   src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_en,
  input  logic [1:0]        ex_md,
  input  logic [RA_W-1:0]   ex_da,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_da,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data,
  output logic              raw_hit,
  output logic              load_hit
);

  logic src_nz;
  logic ex_match;
  logic wb_match;

  assign src_nz   = |src;
  assign ex_match = ex_en & (ex_da == src);
  assign wb_match = wb_en & (wb_da == src);
  assign raw_hit  = src_nz & (ex_match | wb_match);
  assign load_hit = src_nz & ex_match & (ex_md == MD_LOAD);

`ifdef DOF_FWD_EN
  // A load in EX has no data yet, so it must not win the EX slot.
  always_comb begin
    fwd_data = rf_data;
    if (!src_nz)
      fwd_data = '0;
    else if (ex_match && (ex_md != MD_LOAD))
      fwd_data = ex_result;
    else if (wb_match)
      fwd_data = wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, wb_data};
  assign fwd_data   = rf_data;
`endif

endmodule

// File: rtl/dof_pipe_stage.sv
// Registered decode/operand-fetch stage with load-use bubble insertion, stall and flush.
// DOF_FWD_EN enables EX/WB forwarding; without it any pending RAW stalls.
module dof_pipe_stage
  import dof_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int IM_W   = IM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [31:0]       ir_in,
  input  logic [RA_W-1:0]   dec_aa,
  input  logic [RA_W-1:0]   dec_ba,
  input  logic [RA_W-1:0]   dec_da,
  input  logic              dec_rw,
  input  logic              dec_ps,
  input  logic              dec_mw,
  input  logic              dec_ma,
  input  logic              dec_mb,
  input  logic              dec_cs,
  input  logic [1:0]        dec_md,
  input  logic [1:0]        dec_bs,
  input  logic [4:0]        dec_fs,
  input  logic [DATA_W-1:0] adata,
  input  logic [DATA_W-1:0] bdata,
  input  logic              ex_valid,
  input  logic              ex_rw,
  input  logic [1:0]        ex_md,
  input  logic [RA_W-1:0]   ex_da,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_valid,
  input  logic              wb_rw,
  input  logic [RA_W-1:0]   wb_da,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic              hold_fetch,
  output logic              out_valid,
  output logic [RA_W-1:0]   aa,
  output logic [RA_W-1:0]   ba,
  output logic [RA_W-1:0]   da,
  output logic              rw,
  output logic              ps,
  output logic              mw,
  output logic [1:0]        md,
  output logic [1:0]        bs,
  output logic [4:0]        fs,
  output logic [4:0]        sh,
  output logic [DATA_W-1:0] abus,
  output logic [DATA_W-1:0] bbus,
  output logic [PC_W-1:0]   pc_out
);

  typedef struct packed {
    logic              vld;
    logic [RA_W-1:0]   aa;
    logic [RA_W-1:0]   ba;
    logic [RA_W-1:0]   da;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] abus;
    logic [DATA_W-1:0] bbus;
    logic [PC_W-1:0]   pc;
  } stage_t;

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [IM_W-1:0] imm,
                                                       input logic cs);
    logic signed [DATA_W-1:0] r;
    r = {{(DATA_W-IM_W){cs & imm[IM_W-1]}}, imm};
    return r;
  endfunction

  logic              ex_en;
  logic              wb_en;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              raw_a;
  logic              raw_b;
  logic              ldh_a;
  logic              ldh_b;
  logic              blk_a;
  logic              blk_b;
  logic              hazard;
  logic [DATA_W-1:0] imm_ext;
  logic              unused_ir;
  stage_t            stage_d;
  stage_t            stage_p1;

  assign ex_en     = ex_valid & ex_rw;
  assign wb_en     = wb_valid & wb_rw;
  assign imm_ext   = ext_imm(ir_in[IM_W-1:0], dec_cs);
  assign unused_ir = ^ir_in;

  dof_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
    .src(dec_aa), .rf_data(adata),
    .ex_en(ex_en), .ex_md(ex_md), .ex_da(ex_da), .ex_result(ex_result),
    .wb_en(wb_en), .wb_da(wb_da), .wb_data(wb_data),
    .fwd_data(fwd_a), .raw_hit(raw_a), .load_hit(ldh_a)
  );

  dof_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
    .src(dec_ba), .rf_data(bdata),
    .ex_en(ex_en), .ex_md(ex_md), .ex_da(ex_da), .ex_result(ex_result),
    .wb_en(wb_en), .wb_da(wb_da), .wb_data(wb_data),
    .fwd_data(fwd_b), .raw_hit(raw_b), .load_hit(ldh_b)
  );

`ifdef DOF_FWD_EN
  logic unused_raw;
  assign unused_raw = raw_a ^ raw_b;
  assign blk_a      = ldh_a;
  assign blk_b      = ldh_b;
`else
  logic unused_ldh;
  assign unused_ldh = ldh_a ^ ldh_b;
  assign blk_a      = raw_a;
  assign blk_b      = raw_b;
`endif

  // A source only matters when its operand bus actually carries the register.
  assign hazard     = in_valid & ((~dec_ma & blk_a) | (~dec_mb & blk_b));
  assign hold_fetch = ~reset & (hazard | stall);

  always_comb begin
    stage_d      = '0;
    stage_d.ctrl = CTRL_BUBBLE;
    if (!flush && in_valid && !hazard) begin
      stage_d.vld     = 1'b1;
      stage_d.aa      = dec_aa;
      stage_d.ba      = dec_ba;
      stage_d.da      = dec_da;
      stage_d.ctrl.rw = dec_rw;
      stage_d.ctrl.ps = dec_ps;
      stage_d.ctrl.mw = dec_mw;
      stage_d.ctrl.md = dec_md;
      stage_d.ctrl.bs = dec_bs;
      stage_d.ctrl.fs = dec_fs;
      stage_d.ctrl.sh = ir_in[4:0];
      stage_d.abus    = dec_ma ? DATA_W'(pc_in) : fwd_a;
      stage_d.bbus    = dec_mb ? imm_ext : fwd_b;
      stage_d.pc      = pc_in;
    end
  end

  // ---- stage p0 -> p1: flush overrides stall; stall holds everything ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stage_p1 <= '0;
    else if (flush || !stall)
      stage_p1 <= stage_d;
  end

  assign out_valid = stage_p1.vld;
  assign aa        = stage_p1.aa;
  assign ba        = stage_p1.ba;
  assign da        = stage_p1.da;
  assign rw        = stage_p1.ctrl.rw;
  assign ps        = stage_p1.ctrl.ps;
  assign mw        = stage_p1.ctrl.mw;
  assign md        = stage_p1.ctrl.md;
  assign bs        = stage_p1.ctrl.bs;
  assign fs        = stage_p1.ctrl.fs;
  assign sh        = stage_p1.ctrl.sh;
  assign abus      = stage_p1.abus;
  assign bbus      = stage_p1.bbus;
  assign pc_out    = stage_p1.pc;

endmodule

// File: tb/tb_dof_pipe_stage.sv
// Randomized and directed bench for dof_pipe_stage against a behavioural model;
// follows DOF_FWD_EN so either build can be checked.
module tb_dof_pipe_stage;

  logic        clk, reset, in_valid;
  logic [15:0] pc_in;
  logic [31:0] ir_in;
  logic [4:0]  dec_aa, dec_ba, dec_da, dec_fs;
  logic        dec_rw, dec_ps, dec_mw, dec_ma, dec_mb, dec_cs;
  logic [1:0]  dec_md, dec_bs;
  logic [31:0] adata, bdata;
  logic        ex_valid, ex_rw;
  logic [1:0]  ex_md;
  logic [4:0]  ex_da;
  logic [31:0] ex_result;
  logic        wb_valid, wb_rw;
  logic [4:0]  wb_da;
  logic [31:0] wb_data;
  logic        stall, flush;
  logic        hold_fetch, out_valid, rw, ps, mw;
  logic [4:0]  aa, ba, da, fs, sh;
  logic [1:0]  md, bs;
  logic [31:0] abus, bbus;
  logic [15:0] pc_out;

  dof_pipe_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .ir_in(ir_in),
    .dec_aa(dec_aa), .dec_ba(dec_ba), .dec_da(dec_da),
    .dec_rw(dec_rw), .dec_ps(dec_ps), .dec_mw(dec_mw), .dec_ma(dec_ma),
    .dec_mb(dec_mb), .dec_cs(dec_cs), .dec_md(dec_md), .dec_bs(dec_bs),
    .dec_fs(dec_fs), .adata(adata), .bdata(bdata),
    .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_md(ex_md), .ex_da(ex_da),
    .ex_result(ex_result), .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_da(wb_da),
    .wb_data(wb_data), .stall(stall), .flush(flush), .hold_fetch(hold_fetch),
    .out_valid(out_valid), .aa(aa), .ba(ba), .da(da), .rw(rw), .ps(ps), .mw(mw),
    .md(md), .bs(bs), .fs(fs), .sh(sh), .abus(abus), .bbus(bbus), .pc_out(pc_out)
  );

  typedef struct packed {
    logic        vld;
    logic [4:0]  aa, ba, da;
    logic        rw, ps, mw;
    logic [1:0]  md, bs;
    logic [4:0]  fs, sh;
    logic [31:0] abus, bbus;
    logic [15:0] pc;
  } exp_t;

  exp_t cur;
  exp_t snap;
  int   n_chk = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rf);
`ifdef DOF_FWD_EN
    if (s == 0) return 32'd0;
    if (ex_valid && ex_rw && ex_da == s && ex_md != 2'b01) return ex_result;
    if (wb_valid && wb_rw && wb_da == s) return wb_data;
`endif
    return rf;
  endfunction

  function automatic logic blocks(input logic [4:0] s);
    if (s == 0) return 1'b0;
`ifdef DOF_FWD_EN
    return ex_valid && ex_rw && ex_md == 2'b01 && ex_da == s;
`else
    return (ex_valid && ex_rw && ex_da == s) || (wb_valid && wb_rw && wb_da == s);
`endif
  endfunction

  function automatic logic model_hazard();
    return in_valid && ((!dec_ma && blocks(dec_aa)) || (!dec_mb && blocks(dec_ba)));
  endfunction

  function automatic logic [31:0] model_imm();
    logic [31:0] k;
    k = ir_in & 32'h0000_7FFF;
    if (dec_cs && k >= 32'h4000) k = k - 32'h8000;
    return k;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, cur.vld);
    check("aa", aa, cur.aa);
    check("ba", ba, cur.ba);
    check("da", da, cur.da);
    check("rw", rw, cur.rw);
    check("ps", ps, cur.ps);
    check("mw", mw, cur.mw);
    check("md", md, cur.md);
    check("bs", bs, cur.bs);
    check("fs", fs, cur.fs);
    check("sh", sh, cur.sh);
    check("abus", abus, cur.abus);
    check("bbus", bbus, cur.bbus);
    check("pc_out", pc_out, cur.pc);
  endtask

  task automatic step();
    logic hz;
    exp_t nx;
    #1;
    hz = model_hazard();
    check("hold_fetch", hold_fetch, hz || stall);
    nx = '0;
    if (flush) nx = '0;
    else if (stall) nx = cur;
    else if (in_valid && !hz) begin
      nx.vld  = 1'b1;
      nx.aa   = dec_aa;
      nx.ba   = dec_ba;
      nx.da   = dec_da;
      nx.rw   = dec_rw;
      nx.ps   = dec_ps;
      nx.mw   = dec_mw;
      nx.md   = dec_md;
      nx.bs   = dec_bs;
      nx.fs   = dec_fs;
      nx.sh   = ir_in[4:0];
      nx.abus = dec_ma ? {16'h0, pc_in} : src_val(dec_aa, adata);
      nx.bbus = dec_mb ? model_imm() : src_val(dec_ba, bdata);
      nx.pc   = pc_in;
    end
    @(posedge clk);
    #1;
    cur = nx;
    check_outputs();
  endtask

  task automatic clear_inputs();
    in_valid = 1'b1; pc_in = '0; ir_in = '0;
    dec_aa = '0; dec_ba = '0; dec_da = '0; dec_fs = '0;
    dec_rw = 1'b0; dec_ps = 1'b0; dec_mw = 1'b0; dec_ma = 1'b0; dec_mb = 1'b0; dec_cs = 1'b0;
    dec_md = '0; dec_bs = '0; adata = '0; bdata = '0;
    ex_valid = 1'b0; ex_rw = 1'b0; ex_md = '0; ex_da = '0; ex_result = '0;
    wb_valid = 1'b0; wb_rw = 1'b0; wb_da = '0; wb_data = '0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 9) != 0);
    pc_in = 16'($urandom); ir_in = $urandom;
    dec_aa = 5'($urandom_range(0, 3)); dec_ba = 5'($urandom_range(0, 3));
    dec_da = 5'($urandom); dec_fs = 5'($urandom);
    dec_rw = 1'($urandom); dec_ps = 1'($urandom); dec_mw = 1'($urandom);
    dec_ma = 1'($urandom); dec_mb = 1'($urandom); dec_cs = 1'($urandom);
    dec_md = 2'($urandom); dec_bs = 2'($urandom);
    adata = $urandom; bdata = $urandom;
    ex_valid = 1'($urandom); ex_rw = 1'($urandom); ex_md = 2'($urandom);
    ex_da = 5'($urandom_range(0, 3)); ex_result = $urandom;
    wb_valid = 1'($urandom); wb_rw = 1'($urandom);
    wb_da = 5'($urandom_range(0, 3)); wb_data = $urandom;
    stall = ($urandom_range(0, 4) == 0);
    flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur = '0;
    check_outputs();
    check("hold_fetch_in_reset", hold_fetch, 1'b0);
    reset = 1'b0;
    stall = 1'b0;

    // Constant unit and PC select
    clear_inputs();
    ir_in = 32'h0000_7FFF; dec_cs = 1'b1; dec_mb = 1'b1; dec_ma = 1'b1; pc_in = 16'h1234;
    step();
    check("bbus_sext", bbus, 32'hFFFF_FFFF);
    check("abus_pc", abus, 32'h0000_1234);
    dec_cs = 1'b0;
    step();
    check("bbus_zext", bbus, 32'h0000_7FFF);

`ifdef DOF_FWD_EN
    // Forward priority and R0 rule
    clear_inputs();
    dec_aa = 5'd3; adata = 32'd5;
    ex_valid = 1'b1; ex_rw = 1'b1; ex_da = 5'd3; ex_result = 32'd9;
    wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd3; wb_data = 32'd7;
    step();
    check("fwd_ex", abus, 32'd9);
    ex_valid = 1'b0;
    step();
    check("fwd_wb", abus, 32'd7);
    dec_aa = 5'd0; ex_valid = 1'b1; ex_da = 5'd0; wb_da = 5'd0;
    step();
    check("fwd_r0", abus, 32'd0);
    // Load-use bubble then retry with the load in WB
    clear_inputs();
    dec_ba = 5'd4; dec_rw = 1'b1; dec_mw = 1'b1;
    ex_valid = 1'b1; ex_rw = 1'b1; ex_md = 2'b01; ex_da = 5'd4;
    step();
    check("ld_use_bubble", out_valid, 1'b0);
    check("ld_use_rw", rw, 1'b0);
    ex_valid = 1'b0; wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd4; wb_data = 32'd8;
    step();
    check("ld_use_retry", bbus, 32'd8);
    check("ld_use_valid", out_valid, 1'b1);
`else
    // Without forwarding a WB producer holds fetch until it retires
    clear_inputs();
    dec_aa = 5'd2; adata = 32'h0000_00A5;
    wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd2; wb_data = 32'h1111;
    step();
    check("raw_hold", hold_fetch, 1'b1);
    check("raw_bubble", out_valid, 1'b0);
    step();
    check("raw_bubble2", out_valid, 1'b0);
    wb_valid = 1'b0;
    step();
    check("raw_release", out_valid, 1'b1);
    check("raw_rf", abus, 32'h0000_00A5);
`endif

    // Stall freezes outputs; flush beats stall
    clear_inputs();
    dec_aa = 5'd1; adata = 32'hCAFE_0001; dec_rw = 1'b1; pc_in = 16'h0077;
    step();
    snap = cur;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1'b1; flush = 1'b0;
      step();
      check("stall_abus", abus, snap.abus);
      check("stall_pc", pc_out, snap.pc);
    end
    stall = 1'b1; flush = 1'b1;
    step();
    check("stall_flush", out_valid, 1'b0);
    check("stall_flush_rw", rw, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of activity
    clear_inputs();
    pc_in = 16'h0040; stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    cur = '0;
    check_outputs();
    check("hold_fetch_reset", hold_fetch, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold_valid", out_valid, 1'b0);
    reset = 1'b0;
    stall = 1'b0;
    cur = '0;
    step();
    check("post_reset_valid", out_valid, 1'b1);
    check("post_reset_pc", pc_out, 16'h0040);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
